cordic_vectoring_ctrl: RTL
==========================

CORDIC_VECTORING_CTRL -- requirements
Module: cordic_vectoring_ctrl

Interface
REQ-001 Parameter ITERATIONS, default 16, number of micro-rotations per operation (legal range 2..2**IDX_WIDTH).
REQ-002 Parameter IDX_WIDTH, default 4, width of the iteration index.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request a new vectoring operation; sampled only in IDLE.
REQ-006 abort  input  1  synchronous cancel of an operation in progress.
REQ-007 done_ack  input  1  consumer acknowledge of a completed result.
REQ-008 y_sign  input  1  MSB of the current y datapath register (1 = y negative).
REQ-009 ready  output  1  controller idle and accepting start.
REQ-010 busy  output  1  operation in progress (INIT or ITER).
REQ-011 done  output  1  result valid in datapath registers.
REQ-012 sel_init  output  1  datapath mux select: 1 = load initial x/y/z, 0 = load iteration result.
REQ-013 reg_load  output  1  load enable to the x, y and z datapath registers.
REQ-014 iter_idx  output  IDX_WIDTH  current shift amount / arctan table index.
REQ-015 rot_dir  output  1  micro-rotation direction: 1 = x-=y>>i, y+=x>>i, z-=atan(i); 0 = x+=y>>i, y-=x>>i, z+=atan(i).

Function
REQ-016 The controller SHALL be a Moore FSM with states IDLE, INIT, ITER, DONE, plus an IDX_WIDTH-bit iteration counter; all outputs except rot_dir decode from registered state/counter only.
REQ-017 IDLE: ready=1, all other outputs 0; start=1 SHALL move to INIT next edge; start=0 stays IDLE.
REQ-018 INIT: exactly one cycle; reg_load=1, sel_init=1, busy=1, iter_idx=0; counter cleared to 0; next state ITER.
REQ-019 ITER: reg_load=1, sel_init=0, busy=1, iter_idx=counter; counter SHALL increment by 1 each cycle.
REQ-020 ITER SHALL last exactly ITERATIONS cycles (iter_idx 0..ITERATIONS-1); on the cycle iter_idx=ITERATIONS-1 next state is DONE and counter returns to 0 (no wrap past ITERATIONS-1).
REQ-021 rot_dir SHALL equal y_sign combinationally while in ITER, and 0 in all other states.
REQ-022 DONE: done=1, reg_load=0, busy=0, ready=0; held until done_ack=1, then IDLE next edge.
REQ-023 Latency: start sampled at edge N yields done=1 from edge N+ITERATIONS+2; datapath registers receive ITERATIONS+1 loads total.
REQ-024 start asserted in INIT, ITER or DONE SHALL be ignored (not queued).
REQ-025 abort=1 in INIT or ITER SHALL force IDLE next edge with counter cleared; reg_load SHALL be 0 from that edge; done never asserts for the aborted operation.
REQ-026 abort in IDLE or DONE SHALL be ignored; abort and done_ack together in DONE act as done_ack.
REQ-027 done_ack outside DONE SHALL be ignored.
REQ-028 start and done_ack simultaneously in DONE SHALL only return to IDLE; a new start must be presented again in IDLE.

Reset
REQ-029 rst=0 SHALL immediately (without clock) force state IDLE, counter 0, ready=1, busy=0, done=0, sel_init=0, reg_load=0, iter_idx=0, rot_dir=0.
REQ-030 Reset asserted mid-operation SHALL abandon the operation; first edge after rst deassert behaves as IDLE.

Verification
REQ-031 ITERATIONS=16, start pulse at edge 0 -> INIT at 1 (sel_init=1), iter_idx 0..15 at edges 2..17, done=1 from edge 18, reg_load high for 17 cycles total.
REQ-032 y_sign toggled each ITER cycle -> rot_dir tracks y_sign same cycle; rot_dir=0 in IDLE/INIT/DONE regardless of y_sign.
REQ-033 abort at iter_idx=5 -> IDLE next edge, ready=1, reg_load=0, done stays 0; subsequent start runs a full 16-iteration operation from iter_idx 0.
REQ-034 done_ack withheld 10 cycles in DONE -> done held 10 cycles, reg_load=0; start pulses during DONE ignored; done_ack -> IDLE.
REQ-035 rst driven low asynchronously between edges at iter_idx=9 -> outputs reach reset values before next edge; after release, start -> normal operation.
REQ-036 ITERATIONS=2, IDX_WIDTH=1 -> iter_idx 0,1 only, done at start edge +4, counter never wraps.

Source files
------------

// File: rtl/cordic_vectoring_ctrl.sv
//------------------------------------------------------------------------------
// cordic_vectoring_ctrl : sequencer for an iterative CORDIC vectoring datapath
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module cordic_vectoring_ctrl #(
  parameter int ITERATIONS = 16,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 done_ack,
  input  logic                 y_sign,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 sel_init,
  output logic                 reg_load,
  output logic [IDX_WIDTH-1:0] iter_idx,
  output logic                 rot_dir
);

  localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(ITERATIONS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_INIT = 2'd1,
    S_ITER = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e               state_q, state_d;
  logic [IDX_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ready_q, busy_q, done_q, sel_init_q, reg_load_q, iter_q;

  // The counter is zero outside ITER, so it doubles as the iter_idx output.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_INIT;
          cnt_d   = '0;
        end
      end
      S_INIT: begin
        cnt_d   = '0;
        state_d = abort ? S_IDLE : S_ITER;
      end
      S_ITER: begin
        if (abort) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_IDX) begin
          state_d = S_DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + IDX_WIDTH'(1);
        end
      end
      S_DONE: begin
        if (done_ack) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are registered from the next-state decode so they change with the state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sel_init_q <= 1'b0;
      reg_load_q <= 1'b0;
      iter_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= (state_d == S_IDLE);
      busy_q     <= (state_d == S_INIT) || (state_d == S_ITER);
      done_q     <= (state_d == S_DONE);
      sel_init_q <= (state_d == S_INIT);
      reg_load_q <= (state_d == S_INIT) || (state_d == S_ITER);
      iter_q     <= (state_d == S_ITER);
    end
  end

  assign ready    = ready_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign sel_init = sel_init_q;
  assign reg_load = reg_load_q;
  assign iter_idx = cnt_q;
  assign rot_dir  = iter_q & y_sign;

endmodule

`default_nettype wire
